// File: rtl/umi_gpio_pkg.sv
// Shared UMI opcodes and master FSM state encoding for the GPIO-style UMI master.
package umi_gpio_pkg;

    localparam logic [4:0] REQ_READ   = 5'h01;
    localparam logic [4:0] REQ_WRITE  = 5'h03;
    localparam logic [4:0] RESP_READ  = 5'h02;
    localparam logic [4:0] RESP_WRITE = 5'h04;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // UMI size field: log2 of the transfer width in bytes.
    function automatic logic [2:0] umi_size(input int rwidth, input int wwidth);
        int maxw;
        maxw = (rwidth > wwidth) ? rwidth : wwidth;
        return 3'($clog2(maxw / 8));
    endfunction

endpackage

// File: rtl/umi_gpio_timer.sv
// Response timeout counter: cleared outside WAIT, counts WAIT cycles, flags TIMEOUT-1.
module umi_gpio_timer
    import umi_gpio_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic nreset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNTW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNTW-1:0] cnt_q, cnt_d;

    assign expired = enable && !clear && (cnt_q == CNTW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/umi_gpio_master.sv
// Single-outstanding UMI host: turns a local read/write command into one UMI request/response.
// Optional response timeout enabled by defining UMI_GPIO_MASTER_TIMEOUT_EN.
module umi_gpio_master
    import umi_gpio_pkg::*;
#(
    parameter int          DW      = 256,
    parameter int          AW      = 64,
    parameter int          CW      = 32,
    parameter int          RWIDTH  = 32,
    parameter int          WWIDTH  = 32,
    parameter logic [AW-1:0] DSTADDR = '0,
    parameter logic [AW-1:0] SRCADDR = '0,
    parameter int          TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cmd_valid,
    input  logic              cmd_write,
    input  logic [WWIDTH-1:0] cmd_wdata,
    output logic              cmd_ready,
    output logic              rsp_valid,
    output logic [RWIDTH-1:0] rsp_rdata,
    output logic              rsp_error,
    input  logic              rsp_ready,
    output logic              uhost_req_valid,
    output logic [CW-1:0]     uhost_req_cmd,
    output logic [AW-1:0]     uhost_req_dstaddr,
    output logic [AW-1:0]     uhost_req_srcaddr,
    output logic [DW-1:0]     uhost_req_data,
    input  logic              uhost_req_ready,
    input  logic              uhost_resp_valid,
    input  logic [CW-1:0]     uhost_resp_cmd,
    input  logic [AW-1:0]     uhost_resp_dstaddr,
    input  logic [AW-1:0]     uhost_resp_srcaddr,
    input  logic [DW-1:0]     uhost_resp_data,
    output logic              uhost_resp_ready
);

    localparam logic [2:0] SIZE = umi_size(RWIDTH, WWIDTH);

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [WWIDTH-1:0] wdata_q, wdata_d;
    logic [RWIDTH-1:0] rdata_q, rdata_d;
    logic              error_q, error_d;
    logic              expired;

`ifdef UMI_GPIO_MASTER_TIMEOUT_EN
    umi_gpio_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .nreset  (nreset),
        .clear   (state_q != WAIT),
        .enable  (state_q == WAIT),
        .expired (expired)
    );
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign expired        = 1'b0;
`endif

    // Address fields, upper data bits and upper command bits of responses carry nothing we use.
    logic unused_resp;
    assign unused_resp = ^{uhost_resp_cmd[CW-1:5], uhost_resp_dstaddr, uhost_resp_srcaddr,
                           uhost_resp_data[DW-1:RWIDTH]};

    always_comb begin
        uhost_req_cmd      = '0;
        uhost_req_cmd[4:0] = write_q ? REQ_WRITE : REQ_READ;
        uhost_req_cmd[7:5] = SIZE;
    end

    assign cmd_ready         = nreset && (state_q == IDLE);
    assign uhost_req_valid   = (state_q == REQ);
    assign uhost_req_dstaddr = DSTADDR;
    assign uhost_req_srcaddr = SRCADDR;
    assign uhost_req_data    = DW'(wdata_q);
    assign uhost_resp_ready  = (state_q == WAIT);
    assign rsp_valid         = (state_q == DONE);
    assign rsp_rdata         = rdata_q;
    assign rsp_error         = error_q;

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    wdata_d = cmd_write ? cmd_wdata : '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (uhost_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response in the expiry cycle takes priority over the timeout.
                if (uhost_resp_valid) begin
                    rdata_d = write_q ? '0 : uhost_resp_data[RWIDTH-1:0];
                    error_d = (uhost_resp_cmd[4:0] != (write_q ? RESP_WRITE : RESP_READ));
                    state_d = DONE;
                end else if (expired) begin
                    rdata_d = '0;
                    error_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

endmodule

// File: doc/umi_gpio_master.md
UMI_GPIO_MASTER -- requirements
Module: umi_gpio_master

Interface
REQ-001 Parameters SHALL be: DW 256 (UMI data width); AW 64 (address width); CW 32 (command width); RWIDTH 32 (read width); WWIDTH 32 (write width); DSTADDR 0 (target device address); SRCADDR 0 (own return address); TIMEOUT 1024 (response timeout, cycles).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- nreset, in, 1, reset: asynchronous, active-low.
- cmd_valid, in, 1, local command offered.
- cmd_write, in, 1, 1 = write, 0 = read.
- cmd_wdata, in, WWIDTH, write value.
- cmd_ready, out, 1, command accepted.
- rsp_valid, out, 1, completion available.
- rsp_rdata, out, RWIDTH, read value; 0 for writes.
- rsp_error, out, 1, bad opcode or timeout.
- rsp_ready, in, 1, completion consumed.
- uhost_req_valid / cmd / dstaddr / srcaddr / data / ready: out / out / out / out / out / in; widths 1 / CW / AW / AW / DW / 1; UMI request.
- uhost_resp_valid / cmd / dstaddr / srcaddr / data / ready: in / in / in / in / in / out; widths 1 / CW / AW / AW / DW / 1; UMI response.

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-004 In IDLE, cmd_ready SHALL be 1; every other state SHALL drive cmd_ready 0.
REQ-005 cmd_valid & cmd_ready SHALL capture cmd_write and cmd_wdata and go to REQ on the next cycle.
REQ-006 In REQ, uhost_req_valid SHALL be 1 with all request fields constant until uhost_req_ready; then go to WAIT.
REQ-007 Request cmd[4:0] SHALL be 5'h03 (REQ_WRITE) for writes and 5'h01 (REQ_READ) for reads.
REQ-008 Request cmd[7:5] (size) SHALL be clog2(max(RWIDTH,WWIDTH)/8); cmd[15:8] (len) SHALL be 0; remaining cmd bits SHALL be 0.
REQ-009 Request dstaddr SHALL be DSTADDR, srcaddr SHALL be SRCADDR, data SHALL be cmd_wdata zero-extended to DW (0 for reads).
REQ-010 uhost_resp_ready SHALL be 1 only in WAIT; responses arriving in any other state are not accepted.
REQ-011 A WAIT handshake SHALL register rsp_rdata = resp data[RWIDTH-1:0] for reads, 0 for writes, and go to DONE.
REQ-012 In the same handshake, rsp_error SHALL be 1 if resp cmd[4:0] differs from 5'h02 (read) or 5'h04 (write).
REQ-013 DONE SHALL hold rsp_valid 1 with stable rsp_rdata and rsp_error until rsp_ready, then return to IDLE.
REQ-014 Minimum latency SHALL be: cmd accept at cycle N, uhost_req_valid at N+1, rsp_valid one cycle after the response handshake.
REQ-015 At most one transaction SHALL be outstanding; back-to-back commands SHALL see one idle cycle of cmd_ready between them.
REQ-016 Simultaneous request and response valid is impossible by construction; the resp side SHALL be ignored outside WAIT.

Reset
REQ-017 nreset low SHALL force IDLE asynchronously: cmd_ready 0 while nreset is low; uhost_req_valid, uhost_resp_ready, rsp_valid, rsp_error 0; rsp_rdata 0; captured data 0.
REQ-018 Reset mid-transaction SHALL abandon it with no completion; a late response is not accepted.

Configuration
REQ-019 With UMI_GPIO_MASTER_TIMEOUT_EN defined:
- a counter SHALL clear on WAIT entry and increment each WAIT cycle.
- on reaching TIMEOUT-1 with no response, the FSM SHALL go to DONE with rsp_error 1 and rsp_rdata 0.
- a response in the expiry cycle SHALL win, with no error.
REQ-020 Without UMI_GPIO_MASTER_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL wait indefinitely, and the TIMEOUT parameter SHALL be unused.

Structure
REQ-021 UMI opcode constants (REQ_READ, REQ_WRITE, RESP_READ, RESP_WRITE) and the state enum SHALL live in shared package umi_gpio_pkg.
REQ-022 The timeout counter SHALL be sub-module umi_gpio_timer (inputs clear, enable; output expired), instantiated only under the macro.

Verification
REQ-023 Write: cmd_write=1, cmd_wdata=32'hA5A5_0001 -> request cmd[4:0]=03, data=A5A50001, dstaddr=DSTADDR; RESP_WRITE returned -> rsp_valid, rsp_error=0, rsp_rdata=0.
REQ-024 Read: device responds RESP_READ, data=32'h1234_5678 -> rsp_rdata=12345678, rsp_error=0; request size=2 for 32-bit widths.
REQ-025 Backpressure: uhost_req_ready low 5 cycles, then rsp_ready low 3 cycles -> request and completion fields stable throughout; cmd_ready 0 until DONE exits.
REQ-026 Error: read answered with opcode 5'h04 -> rsp_error=1.
REQ-027 Timeout (macro on, TIMEOUT=16): no response -> rsp_error=1 exactly 16 cycles after WAIT entry.
REQ-028 Reset: nreset low while in WAIT -> all outputs 0 immediately; a later response is not accepted; the next command completes normally.
